instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage of the 8-bit 5-stage pipeline; sits directly upstream of the decode stage and masters the program ROM.
- Owns the program counter and drives ROM address_bus / rd_en / rom_enable.
- Assembles each 2-byte instruction (opcode byte, then operand byte) from two ROM reads.
- Hands the instruction to decode over a valid/ready handshake; supports stall and branch redirect.

Parameters:
address_width, 8, ROM address / PC width
data_width, 8, ROM data width; opcode and operand width
HALT_OPCODE, 8'hFF, opcode that halts fetch (used only with FETCH_HALT_EN)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
address_bus  output  address_width  ROM address, always equals PC
rd_en  output  1  ROM read enable, active high
wr_en  output  1  ROM write enable, constant 0
rom_enable  output  1  ROM chip enable, active low
data_bus  input  data_width  ROM read data; the unit never drives it
stall  input  1  freeze fetch progress
branch_taken  input  1  redirect PC this edge
branch_target  input  address_width  new PC on redirect
instr_valid  output  1  instruction presented to decode
instr_ready  input  1  decode accepts the instruction
instr_opcode  output  data_width  opcode byte
instr_operand  output  data_width  operand byte
instr_pc  output  address_width  address of the opcode byte
halted  output  1  fetch halted (see Optional Feature)

Behaviour:
- Reset (async, while high): pc=0, state=IDLE, address_bus=0, rd_en=0, wr_en=0, rom_enable=1, instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=0, halted=0.
- States: IDLE, FETCH_OP, FETCH_ARG, PRESENT (plus HALTED with macro).
- IDLE: one cycle after reset release, then FETCH_OP.
- ROM strobes: rd_en=1 and rom_enable=0 only in FETCH_OP and FETCH_ARG; otherwise rd_en=0 and rom_enable=1. address_bus=pc in all states.
- ROM read is combinational. data_bus is sampled on the rising edge that ends the cycle the address was driven.
- FETCH_OP edge, no stall: opcode_reg<=data_bus, instr_pc<=pc, pc<=pc+1, go to FETCH_ARG.
- FETCH_ARG edge, no stall: operand_reg<=data_bus, pc<=pc+1, go to PRESENT.
- PRESENT: instr_valid=1. Opcode, operand and instr_pc are stable until instr_ready is high at an edge, then go to FETCH_OP.
- Minimum 3 cycles per instruction.
- stall high in FETCH_OP or FETCH_ARG: no capture, pc holds, state holds, strobes stay asserted. stall is ignored in PRESENT and IDLE.
- branch_taken at an edge overrides stall:
  - pc<=branch_target; state to FETCH_OP; any partially fetched instruction is discarded; instr_valid<=0.
  - In PRESENT with instr_ready=1 in the same edge, the instruction counts as consumed, then the redirect applies.
  - In PRESENT with instr_ready=0, the presented instruction is dropped.
- PC arithmetic is modulo 2^address_width: 0xFF+1 wraps to 0x00. An opcode at 0xFF takes its operand from 0x00.
- wr_en is never asserted.
- halted=0 at all times unless FETCH_HALT_EN is defined.

Optional Feature:
Macro FETCH_HALT_EN.
- Defined:
  - When the instruction in PRESENT has opcode==HALT_OPCODE and completes its handshake, go to HALTED.
  - HALTED: halted=1, rd_en=0, rom_enable=1, instr_valid=0, pc holds.
  - Exit only on reset (to IDLE) or branch_taken (to FETCH_OP at branch_target, halted<=0).
- Undefined: HALTED state is absent, HALT_OPCODE is an ordinary opcode, halted is tied 0.

Test Plan:
1. ROM 00:10 01:22 02:30 03:44; reset released, instr_ready=1 -> first (opcode 10, operand 22, pc 00), next (30, 44, pc 02); rd_en asserted exactly 2 of every 3 cycles.
2. After the first instruction, instr_ready=0 for 5 cycles -> instr_valid held 1, outputs stay 10/22/00, rd_en=0, address_bus=02; ready=1 resumes fetch at 02.
3. stall=1 for 3 cycles in FETCH_ARG at address 01 -> address_bus stays 01 with rd_en=1, pc does not advance; operand 22 captured on the edge after stall drops.
4. branch_taken=1 with target 0x80 during FETCH_ARG, ROM 80:5A 81:01 -> partial instruction discarded, no valid for it; next instruction 5A/01 with instr_pc 80.
5. Branch to FF, ROM FF:55 00:66 -> opcode 55, operand 66, instr_pc FF; next fetch address 01.
6. FETCH_HALT_EN defined, ROM 04:FF 05:00 -> after handshake halted=1, rd_en=0 for 10+ cycles; branch_taken to 10 clears halted and fetches from 10. Macro undefined -> FF/00 presented normally, fetch continues at 06.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads 2-byte instructions (opcode, operand) from the program ROM.
// Ports: clock/reset, ROM master (address_bus, rd_en, wr_en, rom_enable, data_bus),
//        control (stall, branch_taken, branch_target), decode handshake (instr_*), halted.
// Optional: define FETCH_HALT_EN to stop fetching after a HALT_OPCODE instruction is accepted.
module instr_fetch_unit #(
    parameter int                    address_width = 8,
    parameter int                    data_width    = 8,
    parameter logic [data_width-1:0] HALT_OPCODE   = 8'hFF
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [address_width-1:0] address_bus,
    output logic                     rd_en,
    output logic                     wr_en,
    output logic                     rom_enable,
    input  logic [data_width-1:0]    data_bus,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [address_width-1:0] branch_target,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [data_width-1:0]    instr_opcode,
    output logic [data_width-1:0]    instr_operand,
    output logic [address_width-1:0] instr_pc,
    output logic                     halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_OP,
        FETCH_ARG,
        PRESENT
`ifdef FETCH_HALT_EN
        , HALTED
`endif
    } state_t;

    localparam logic [address_width-1:0] PC_ONE = {{(address_width-1){1'b0}}, 1'b1};

    state_t                   state, state_nxt;
    logic [address_width-1:0] pc, pc_nxt;
    logic                     cap_op, cap_arg;

    assign address_bus = pc;
    assign wr_en       = 1'b0;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        cap_op      = 1'b0;
        cap_arg     = 1'b0;
        rd_en       = 1'b0;
        rom_enable  = 1'b1;
        instr_valid = 1'b0;
        halted      = 1'b0;

        case (state)
            IDLE: state_nxt = FETCH_OP;
            FETCH_OP: begin
                rd_en      = 1'b1;
                rom_enable = 1'b0;
                if (!stall) begin
                    cap_op    = 1'b1;
                    pc_nxt    = pc + PC_ONE;
                    state_nxt = FETCH_ARG;
                end
            end
            FETCH_ARG: begin
                rd_en      = 1'b1;
                rom_enable = 1'b0;
                if (!stall) begin
                    cap_arg   = 1'b1;
                    pc_nxt    = pc + PC_ONE;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
`ifdef FETCH_HALT_EN
                    state_nxt = (instr_opcode == HALT_OPCODE) ? HALTED : FETCH_OP;
`else
                    state_nxt = FETCH_OP;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            HALTED: halted = 1'b1;
`endif
            default: state_nxt = IDLE;
        endcase

        // A redirect wins over stall and over any half-assembled instruction;
        // a presented instruction is either consumed this edge or dropped.
        if (branch_taken) begin
            state_nxt = FETCH_OP;
            pc_nxt    = branch_target;
            cap_op    = 1'b0;
            cap_arg   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= '0;
            instr_opcode  <= '0;
            instr_operand <= '0;
            instr_pc      <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (cap_op) begin
                instr_opcode <= data_bus;
                instr_pc     <= pc;
            end
            if (cap_arg) begin
                instr_operand <= data_bus;
            end
        end
    end

endmodule
